// File: rtl/rv_pkg.sv
// Shared RV32I execute-stage definitions.
// Holds the funct3 operation codes, the funct7 bit that selects the
// alternate form (SUB / SRA) and the integer datapath width.
package rv_pkg;

   localparam int XLEN       = 32;
   localparam int F7_ALT_BIT = 5;

   localparam logic [2:0] F3_ADD  = 3'b000;  // ADD / SUB
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;  // SRL / SRA
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

endpackage

// File: rtl/rv_alu_core.sv
// Combinational RV32I integer ALU core.
// Ports:
//   fun3 - funct3 operation select
//   alt  - funct7[5], picks SUB over ADD and SRA over SRL
//   a, b - operands
//   res  - result (no flags)
// Kept free of state so it can also serve branch compare and address
// generation.
module rv_alu_core #(
   parameter int XLEN = rv_pkg::XLEN
) (
   input  logic [2:0]      fun3,
   input  logic            alt,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic [XLEN-1:0] res
);
   import rv_pkg::*;

   localparam int SHW = $clog2(XLEN);

   logic signed [XLEN-1:0] a_s;
   logic signed [XLEN-1:0] b_s;
   logic        [SHW-1:0]  shamt;

   assign a_s   = a;
   assign b_s   = b;
   // Only the low bits of b form the shift amount; the rest are ignored.
   assign shamt = b[SHW-1:0];

   always_comb begin
      res = '0;
      case (fun3)
         F3_ADD:  res = alt ? (a - b) : (a + b);
         F3_SLL:  res = a << shamt;
         F3_SLT:  res = {{(XLEN-1){1'b0}}, (a_s < b_s)};
         F3_SLTU: res = {{(XLEN-1){1'b0}}, (a < b)};
         F3_XOR:  res = a ^ b;
         F3_SR:   res = alt ? XLEN'(a_s >>> shamt) : (a >> shamt);
         F3_OR:   res = a | b;
         F3_AND:  res = a & b;
         default: res = '0;
      endcase
   end

endmodule

// File: rtl/rv_alu.sv
// Registered RV32I execute-stage ALU.
// Ports:
//   clk    - rising-edge clock
//   rst    - asynchronous active-high reset, clears ALUout at once
//   fun3   - funct3, selects the operation
//   func7  - funct7, only bit 5 (alternate form) is decoded
//   ALUin1 - operand A (rs1)
//   ALUin2 - operand B (rs2 or immediate)
//   ALUout - result, registered with one cycle of latency
module rv_alu #(
   parameter int XLEN = rv_pkg::XLEN
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [2:0]      fun3,
   input  logic [6:0]      func7,
   input  logic [XLEN-1:0] ALUin1,
   input  logic [XLEN-1:0] ALUin2,
   output logic [XLEN-1:0] ALUout
);
   import rv_pkg::*;

   logic [XLEN-1:0] res;
   logic            alt;
   logic            unused_f7;

   assign alt       = func7[F7_ALT_BIT];
   // Remaining funct7 bits carry no meaning for these operations.
   assign unused_f7 = ^{func7[6], func7[4:0]};

   rv_alu_core #(.XLEN(XLEN)) u_core (
      .fun3 (fun3),
      .alt  (alt),
      .a    (ALUin1),
      .b    (ALUin2),
      .res  (res)
   );

   // Output register stage: reloads every cycle, cleared by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) ALUout <= '0;
      else     ALUout <= res;
   end

endmodule

// File: tb/tb_rv_alu.sv
module tb_rv_alu;

   logic        clk;
   logic        rst;
   logic [2:0]  fun3;
   logic [6:0]  func7;
   logic [31:0] ALUin1;
   logic [31:0] ALUin2;
   logic [31:0] ALUout;

   int checks = 0;
   int errors = 0;

   rv_alu #(.XLEN(32)) dut (
      .clk    (clk),
      .rst    (rst),
      .fun3   (fun3),
      .func7  (func7),
      .ALUin1 (ALUin1),
      .ALUin2 (ALUin2),
      .ALUout (ALUout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model derived from the instruction semantics.
   function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic [6:0] f7,
                                           input logic [31:0] a, input logic [31:0] b);
      int unsigned sh;
      logic [31:0] mask;
      logic        alt;
      alt = f7[5];
      sh  = b % 32;
      case (f3)
         3'd0: ref_alu = alt ? a + (~b + 32'd1) : a + b;
         3'd1: ref_alu = a * (32'd1 << sh);
         3'd2: ref_alu = (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, (a < b)};
         3'd3: ref_alu = (a < b) ? 32'd1 : 32'd0;
         3'd4: ref_alu = a ^ b;
         3'd5: begin
            mask = 32'hFFFF_FFFF >> sh;
            ref_alu = (a / (32'd1 << sh));
            if (alt && a[31]) ref_alu = ref_alu | ~mask;
         end
         3'd6: ref_alu = a | b;
         default: ref_alu = a & b;
      endcase
   endfunction

   task automatic drive(input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] a, input logic [31:0] b);
      fun3 = f3; func7 = f7; ALUin1 = a; ALUin2 = b;
   endtask

   // Drive, clock once, sample 1 time unit after the edge.
   task automatic apply(input string tag, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
      drive(f3, f7, a, b);
      @(posedge clk);
      #1;
      check(tag, ALUout, exp);
   endtask

   logic [31:0] ra, rb;
   logic [2:0]  rf3;
   logic [6:0]  rf7;

   initial begin
      rst = 1'b0;
      drive(3'd0, 7'd0, 32'd0, 32'd0);
      #1 rst = 1'b1;
      #2 check("reset_async", ALUout, 32'h0);
      @(posedge clk); @(posedge clk); #1;
      check("reset_hold", ALUout, 32'h0);
      rst = 1'b0;

      // Directed vectors
      apply("add",        3'b000, 7'b0000000, 32'd5, 32'd7, 32'h0000000C);
      apply("sub",        3'b000, 7'b0100000, 32'd5, 32'd7, 32'hFFFFFFFE);
      apply("sll",        3'b001, 7'b0000000, 32'd5, 32'd7, 32'h00000280);
      apply("and57",      3'b111, 7'b0000000, 32'd5, 32'd7, 32'h00000005);
      apply("srl",        3'b101, 7'b0000000, 32'h80000000, 32'h24, 32'h08000000);
      apply("sra",        3'b101, 7'b0100000, 32'h80000000, 32'h24, 32'hF8000000);
      apply("sll_sh0",    3'b001, 7'b0000000, 32'h12345678, 32'h20, 32'h12345678);
      apply("sra_sh0",    3'b101, 7'b0100000, 32'h87654321, 32'hFFFFFFE0, 32'h87654321);
      apply("slt",        3'b010, 7'b0000000, 32'hFFFFFFFF, 32'd1, 32'd1);
      apply("sltu",       3'b011, 7'b0000000, 32'hFFFFFFFF, 32'd1, 32'd0);
      apply("slt_swap",   3'b010, 7'b0000000, 32'd1, 32'hFFFFFFFF, 32'd0);
      apply("sltu_swap",  3'b011, 7'b0000000, 32'd1, 32'hFFFFFFFF, 32'd1);
      apply("slt_eq",     3'b010, 7'b0100000, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'd0);
      apply("sltu_eq",    3'b011, 7'b1111111, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'd0);
      apply("xor",        3'b100, 7'b0000000, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0);
      apply("or",         3'b110, 7'b0000000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0);
      apply("and",        3'b111, 7'b0000000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000);
      apply("add_ovf",    3'b000, 7'b0000000, 32'hFFFFFFFF, 32'd1, 32'h00000000);
      apply("add_f7junk", 3'b000, 7'b1011111, 32'd5, 32'd7, 32'h0000000C);
      apply("or_alt",     3'b110, 7'b0100000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0);

      // Input change between edges must not reach the output early
      apply("add_pre",    3'b000, 7'b0000000, 32'd5, 32'd7, 32'h0000000C);
      ALUin1 = 32'd100;
      #3 check("no_early", ALUout, 32'h0000000C);
      @(posedge clk); #1;
      check("next_edge", ALUout, 32'd107);

      // Reset asserted mid-operation with a nonzero output
      rst = 1'b1;
      #2 check("rst_mid", ALUout, 32'h0);
      @(posedge clk); #1;
      check("rst_mid_hold", ALUout, 32'h0);
      drive(3'b100, 7'd0, 32'hDEADBEEF, 32'h0F0F0F0F);
      rst = 1'b0;
      @(posedge clk); #1;
      check("rst_release", ALUout, 32'hD1A2B1E0);

      // Randomized vectors against the reference model
      for (int i = 0; i < 400; i++) begin
         rf3 = 3'($urandom_range(0, 7));
         rf7 = 7'($urandom);
         ra  = $urandom;
         rb  = $urandom;
         case ($urandom_range(0, 7))
            0: ra = 32'h80000000;
            1: rb = 32'hFFFFFFFF;
            2: rb = ra;
            3: ra = 32'hFFFFFFFF;
            default: ;
         endcase
         apply($sformatf("rand%0d_f3_%0d", i, rf3), rf3, rf7, ra, rb, ref_alu(rf3, rf7, ra, rb));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
